afifo_rd_packer: RTL and testbench



---
 rtl/afifo_rd_packer.sv | 113 +++++++++++
 tb/tb_afifo_rd_packer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_packer.sv
// Read-side packer for the byte-wide async FIFO: gathers NBYTES fall-through bytes
// little-endian into one word on a valid/ready stream; flush emits a partial word.
module afifo_rd_packer #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned CW     = 16
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [7:0]          fifo_dout,
    output logic                fifo_rd_en,
    input  logic                flush,
    output logic [8*NBYTES-1:0] m_data,
    output logic [NBYTES-1:0]   m_keep,
    output logic                m_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CW-1:0]       words_out,
    output logic                busy
);
    localparam int unsigned     CNTW     = $clog2(NBYTES + 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NBYTES);

    logic [8*NBYTES-1:0] asm_q, asm_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [8*NBYTES-1:0] data_q, data_d;
    logic [NBYTES-1:0]   keep_q, keep_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       words_q, words_d;

    logic cnt_full;
    logic cnt_nz;
    logic slot_free;
    logic hold_pops;
    logic full_load;
    logic flush_load;
    logic load;

    always_comb begin
        cnt_full   = (cnt_q == CNT_FULL);
        cnt_nz     = (cnt_q != '0);
        slot_free  = !valid_q || m_ready;
        // A pending flush freezes the partial word until the output slot frees up.
        hold_pops  = flush && cnt_nz;
        fifo_rd_en = !rst && !fifo_empty && !cnt_full && !hold_pops;
        full_load  = cnt_full && slot_free;
        flush_load = hold_pops && !cnt_full && slot_free;
        load       = full_load || flush_load;
    end

    always_comb begin
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        words_d = words_q;

        if (valid_q && m_ready) begin
            valid_d = 1'b0;
            words_d = words_q + CW'(1);
        end

        // Load and pop are mutually exclusive: both load paths force fifo_rd_en low.
        if (load) begin
            data_d  = asm_q;
            last_d  = flush_load;
            valid_d = 1'b1;
            for (int i = 0; i < NBYTES; i++) begin
                keep_d[i] = (CNTW'(i) < cnt_q);
            end
            asm_d = '0;
            cnt_d = '0;
        end else if (fifo_rd_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (CNTW'(i) == cnt_q) begin
                    asm_d[8*i +: 8] = fifo_dout;
                end
            end
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            words_q <= '0;
        end else begin
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            words_q <= words_d;
        end
    end

    assign m_data    = data_q;
    assign m_keep    = keep_q;
    assign m_last    = last_q;
    assign m_valid   = valid_q;
    assign words_out = words_q;
    assign busy      = cnt_nz || valid_q;

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Bench for afifo_rd_packer: directed table, corner sequences, and a randomized run
// scored against the pushed byte stream.
module tb_afifo_rd_packer;
    localparam int unsigned NB  = 4;
    localparam int unsigned CWT = 8;

    logic           rclk = 1'b0;
    logic           rst;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic           fifo_rd_en;
    logic           flush;
    logic [31:0]    m_data;
    logic [NB-1:0]  m_keep;
    logic           m_last;
    logic           m_valid;
    logic           m_ready;
    logic [CWT-1:0] words_out;
    logic           busy;

    int total = 0;
    int bad   = 0;

    afifo_rd_packer #(.NBYTES(NB), .CW(CWT)) dut (
        .rclk       (rclk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .words_out  (words_out),
        .busy       (busy)
    );

    always #5 rclk = ~rclk;

    // Fall-through FIFO model; its memory doubles as the record of pushed bytes.
    logic [7:0] fmem [0:1023];
    logic [9:0] wp = '0;
    logic [9:0] rp = '0;
    assign fifo_empty = (wp == rp);
    assign fifo_dout  = fmem[rp];
    always @(posedge rclk) if (fifo_rd_en) rp <= rp + 10'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting, expected event", name);
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wp] = b;
        wp = wp + 10'd1;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (wp != rp && c < 20) begin
            step();
            c++;
        end
        if (wp != rp) timeout(name);
    endtask

    task automatic wait_valid(input string name, input int lim);
        int c = 0;
        while (m_valid !== 1'b1 && c < lim) begin
            step();
            c++;
        end
        if (m_valid !== 1'b1) timeout(name);
    endtask

    // Negedge monitor: word counter model, stall stability, no empty pops, scoreboard.
    logic           mon_en = 1'b0;
    logic           sb_en  = 1'b0;
    logic [9:0]     sb_rp  = '0;
    logic [CWT-1:0] acc    = '0;
    logic           prev_stall = 1'b0;
    logic [31:0]    prev_data  = '0;
    logic [NB-1:0]  prev_keep  = '0;
    logic           prev_last  = 1'b0;

    always @(negedge rclk) begin
        logic [9:0] idx;
        idx = sb_rp;
        if (mon_en) begin
            chk("words_out", words_out, acc);
            chk("pop_when_empty", fifo_rd_en & fifo_empty, 0);
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_keep", m_keep, prev_keep);
                chk("hold_last", m_last, prev_last);
            end
            if (sb_en && m_valid && m_ready && !rst) begin
                chk("keep_nonzero", m_keep != 0, 1);
                chk("keep_shape", m_keep & (m_keep + 4'd1), 0);
                chk("last_vs_keep", m_last, m_keep != 4'hF);
                for (int i = 0; i < NB; i++) begin
                    if (m_keep[i]) begin
                        chk("sb_byte", m_data[8*i +: 8], fmem[idx]);
                        idx = idx + 10'd1;
                    end else begin
                        chk("sb_pad_zero", m_data[8*i +: 8], 0);
                    end
                end
            end
        end
        sb_rp      <= sb_en ? idx : wp;
        prev_stall <= mon_en && m_valid && !m_ready && !rst;
        prev_data  <= m_data;
        prev_keep  <= m_keep;
        prev_last  <= m_last;
        if (rst) acc <= '0;
        else if (m_valid && m_ready) acc <= acc + 8'd1;
    end

    typedef struct {
        int            n;
        logic [31:0]   bytes;
        logic          fl;
        logic [31:0]   data;
        logic [NB-1:0] keep;
        logic          last;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] got [4];
    int          at  [4];
    int          nseen;
    int          nw;
    logic [31:0] v;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF, 1'b0};
        tbl[1] = '{3, 32'h00CCBBAA, 1'b1, 32'h00CCBBAA, 4'h7, 1'b1};
        tbl[2] = '{1, 32'h000000DD, 1'b1, 32'h000000DD, 4'h1, 1'b1};
        tbl[3] = '{2, 32'h00003412, 1'b1, 32'h00003412, 4'h3, 1'b1};
        tbl[4] = '{4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0};
        tbl[5] = '{4, 32'h04030201, 1'b0, 32'h04030201, 4'hF, 1'b0};

        rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
        repeat (3) step();
        chk("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        #1;
        chk("rst_data", m_data, 0);
        chk("rst_keep", m_keep, 0);
        chk("rst_last", m_last, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_words", words_out, 0);
        chk("rst_busy", busy, 0);
        mon_en = 1'b1;

        for (int k = 0; k < 6; k++) begin
            v = tbl[k].bytes;
            for (int i = 0; i < tbl[k].n; i++) push(v[8*i +: 8]);
            drain("tbl_drain");
            if (tbl[k].fl) flush = 1'b1;
            wait_valid("tbl_valid", 8);
            flush = 1'b0;
            chk("tbl_data", m_data, tbl[k].data);
            chk("tbl_keep", m_keep, tbl[k].keep);
            chk("tbl_last", m_last, tbl[k].last);
            step();
            chk("tbl_one_cycle", m_valid, 0);
        end

        // Continuous stream: three words, five cycles apart.
        for (int i = 1; i <= 12; i++) push(8'(i));
        nseen = 0;
        for (int i = 0; i < 4; i++) begin got[i] = '0; at[i] = 0; end
        for (int c = 0; c < 30; c++) begin
            step();
            if (m_valid && nseen < 4) begin
                got[nseen] = m_data;
                at[nseen]  = c;
                nseen++;
            end
        end
        chk("stream_count", nseen, 3);
        chk("stream_w0", got[0], 32'h04030201);
        chk("stream_w1", got[1], 32'h08070605);
        chk("stream_w2", got[2], 32'h0C0B0A09);
        chk("stream_gap01", at[1] - at[0], 5);
        chk("stream_gap12", at[2] - at[1], 5);

        // Stalled output: second word assembles, pops stop, then drains on release.
        m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        repeat (15) step();
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, 32'h04030201);
        chk("stall_left", 10'(wp - rp), 4);
        chk("stall_busy", busy, 1);
        m_ready = 1'b1;
        step();
        chk("release_data", m_data, 32'h08070605);
        chk("release_valid", m_valid, 1);
        step();
        chk("release_gap", m_valid, 0);
        wait_valid("release_w3", 10);
        chk("release_w3", m_data, 32'h0C0B0A09);
        step();

        // Flush with nothing packed is a no-op.
        flush = 1'b1;
        repeat (3) begin
            step();
            chk("flush_idle_valid", m_valid, 0);
            chk("flush_idle_busy", busy, 0);
        end
        flush = 1'b0;

        // Flush held while the slot is occupied: pops stay frozen until the partial loads.
        m_ready = 1'b0;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        wait_valid("fs_first", 10);
        push(8'hB0); push(8'hB1);
        drain("fs_drain_b");
        flush = 1'b1;
        push(8'hC0); push(8'hC1); push(8'hC2);
        repeat (5) step();
        chk("fs_no_pops", 10'(wp - rp), 3);
        chk("fs_hold_data", m_data, 32'hA3A2A1A0);
        m_ready = 1'b1;
        step();
        chk("fs_data", m_data, 32'h0000B1B0);
        chk("fs_keep", m_keep, 4'h3);
        chk("fs_last", m_last, 1);
        flush = 1'b0;
        step();
        drain("fs_drain_c");
        flush = 1'b1;
        wait_valid("fs_c", 5);
        flush = 1'b0;
        chk("fs_c_data", m_data, 32'h00C2C1C0);
        chk("fs_c_keep", m_keep, 4'h7);
        step();
        chk("fs_c_done", m_valid, 0);

        // Reset mid-word with a held output word.
        m_ready = 1'b0;
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        wait_valid("rw_first", 10);
        push(8'h20); push(8'h21);
        drain("rw_drain");
        rst = 1'b1;
        push(8'h77);
        #1;
        chk("rw_rd_en", fifo_rd_en, 0);
        step();
        rst = 1'b0;
        chk("rw_data", m_data, 0);
        chk("rw_keep", m_keep, 0);
        chk("rw_last", m_last, 0);
        chk("rw_valid", m_valid, 0);
        chk("rw_words", words_out, 0);
        chk("rw_busy", busy, 0);
        m_ready = 1'b1;
        push(8'h88); push(8'h99); push(8'hAA);
        wait_valid("rw_next", 10);
        chk("rw_next_data", m_data, 32'hAA998877);
        chk("rw_next_keep", m_keep, 4'hF);
        step();

        // Randomized traffic scored against the pushed byte order.
        sb_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) != 0 && 10'(wp - rp) < 10'd16) push(8'($urandom_range(0, 255)));
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 9) == 0);
            step();
        end
        m_ready = 1'b1;
        nw = 0;
        while ((busy || !fifo_empty) && nw < 60) begin
            flush = fifo_empty;
            step();
            nw++;
        end
        flush = 1'b0;
        if (busy || !fifo_empty) timeout("rand_drain");
        step();
        chk("rand_all_bytes", sb_rp, wp);
        sb_en = 1'b0;

        // Counter wrap: 2^CW accepted words return words_out to zero.
        rst = 1'b1;
        step();
        rst = 1'b0;
        nw = 0;
        for (int c = 0; c < 3000 && nw < 256; c++) begin
            if (10'(wp - rp) < 10'd8) push(8'(c));
            step();
            if (m_valid) nw++;
        end
        chk("wrap_count", nw, 256);
        chk("wrap_pre", words_out, 8'hFF);
        step();
        chk("wrap_zero", words_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
